// File: rtl/branch_resolve_if.sv
// Purpose : bundles the ID-stage branch/jump resolver inputs and its PC/pipeline-control outputs.
// Latency : wires only; no storage.
// Backpressure: none of its own; Stall/stallJ carry the freeze requests into the resolver.
//
// Ports (master = ID stage / forwarding unit side, slave = branch_resolve):
//   ID inputs   : Stall, Branch, BranchNe, Jump, JumpR, ID_PC4, ID_Imm, ID_JAddr
//   operands    : RegJumpData, RegRtData, EXMEM_ALUResult, MEMWB_WriteData, ForwardJA, ForwardJB, stallJ
//   controls    : PCSrc, PCTarget, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush
//   statistics  : StallCnt, TakenCnt (CNT_W bits, saturating)
interface branch_resolve_if #(
  parameter int CNT_W = 16
);
  logic             Stall;
  logic             Branch;
  logic             BranchNe;
  logic             Jump;
  logic             JumpR;
  logic [31:0]      ID_PC4;
  logic [15:0]      ID_Imm;
  logic [25:0]      ID_JAddr;
  logic [31:0]      RegJumpData;
  logic [31:0]      RegRtData;
  logic [31:0]      EXMEM_ALUResult;
  logic [31:0]      MEMWB_WriteData;
  logic [1:0]       ForwardJA;
  logic [1:0]       ForwardJB;
  logic             stallJ;
  logic             PCSrc;
  logic [31:0]      PCTarget;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] TakenCnt;

  modport master (
    output Stall, Branch, BranchNe, Jump, JumpR, ID_PC4, ID_Imm, ID_JAddr,
           RegJumpData, RegRtData, EXMEM_ALUResult, MEMWB_WriteData,
           ForwardJA, ForwardJB, stallJ,
    input  PCSrc, PCTarget, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
           StallCnt, TakenCnt
  );

  modport slave (
    input  Stall, Branch, BranchNe, Jump, JumpR, ID_PC4, ID_Imm, ID_JAddr,
           RegJumpData, RegRtData, EXMEM_ALUResult, MEMWB_WriteData,
           ForwardJA, ForwardJB, stallJ,
    output PCSrc, PCTarget, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
           StallCnt, TakenCnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Purpose : ID-stage branch/jump resolver: forwarded operands, BEQ/BNE compare, target select, PC redirect.
// Latency : redirect is combinational in the resolving cycle; a redirect caught by a global Stall is held.
// Backpressure: stallJ holds PC/IF-ID and bubbles ID/EX one cycle per hazard cycle; Stall freezes everything.
//
// Ports: clk, rst (async, active-high), bus (branch_resolve_if.slave) carrying the ID inputs,
//        forwarding selects and the PCSrc/PCTarget/PC_Write/IFID_*/IDEX_Flush/StallCnt/TakenCnt outputs.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HAZ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNxt;
  logic [31:0]      holdTarget;
  logic [31:0]      holdTargetNxt;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] takenCnt;
  logic             stallInc;
  logic             takenInc;

  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] brTarget;
  logic [31:0] jTarget;
  logic [31:0] target;
  logic        eq;
  logic        take;
  logic        haz;

  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        pcWrite;
  logic        ifidWrite;
  logic        ifidFlush;
  logic        idexFlush;

  // Operand muxes: 11 falls back to the register file like 00.
  always_comb begin
    case (bus.ForwardJA)
      2'b01:   opA = bus.EXMEM_ALUResult;
      2'b10:   opA = bus.MEMWB_WriteData;
      default: opA = bus.RegJumpData;
    endcase
    case (bus.ForwardJB)
      2'b01:   opB = bus.EXMEM_ALUResult;
      2'b10:   opB = bus.MEMWB_WriteData;
      default: opB = bus.RegRtData;
    endcase
  end

  assign eq       = (opA == opB);
  assign brTarget = bus.ID_PC4 + {{14{bus.ID_Imm[15]}}, bus.ID_Imm, 2'b00};
  assign jTarget  = {bus.ID_PC4[31:28], bus.ID_JAddr, 2'b00};
  assign target   = bus.JumpR ? opA : (bus.Jump ? jTarget : brTarget);
  assign take     = bus.Jump | bus.JumpR | (bus.Branch & (bus.BranchNe ? !eq : eq));
  // J carries its target in the instruction, so only register-sourced resolves wait on stallJ.
  assign haz      = bus.stallJ & (bus.Branch | bus.JumpR);

  always_comb begin
    stateNxt      = state;
    holdTargetNxt = holdTarget;
    pcSrc         = 1'b0;
    pcTarget      = 32'd0;
    pcWrite       = 1'b1;
    ifidWrite     = 1'b1;
    ifidFlush     = 1'b0;
    idexFlush     = 1'b0;
    stallInc      = 1'b0;
    takenInc      = 1'b0;
    case (state)
      HOLD: begin
        // Redirect already resolved; ID contents may have moved on, so only holdTarget matters.
        pcSrc    = 1'b1;
        pcTarget = holdTarget;
        if (bus.Stall) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
        end else begin
          ifidFlush = 1'b1;
          takenInc  = 1'b1;
          stateNxt  = IDLE;
        end
      end
      IDLE, HAZ: begin
        if (bus.Stall) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          if (haz) begin
            stateNxt = HAZ;
          end else if (take) begin
            holdTargetNxt = target;
            stateNxt      = HOLD;
          end
        end else if (haz) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          idexFlush = 1'b1;
          stallInc  = 1'b1;
          stateNxt  = HAZ;
        end else if (take) begin
          pcSrc     = 1'b1;
          pcTarget  = target;
          ifidFlush = 1'b1;
          takenInc  = 1'b1;
          stateNxt  = IDLE;
        end else begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      holdTarget <= 32'd0;
      stallCnt   <= '0;
      takenCnt   <= '0;
    end else begin
      state      <= stateNxt;
      holdTarget <= holdTargetNxt;
      if (stallInc && (stallCnt != {CNT_W{1'b1}})) stallCnt <= stallCnt + 1'b1;
      if (takenInc && (takenCnt != {CNT_W{1'b1}})) takenCnt <= takenCnt + 1'b1;
    end
  end

  // While rst is high the ID inputs still feed the comb logic, so force the safe values here.
  assign bus.PCSrc      = pcSrc & ~rst;
  assign bus.PCTarget   = rst ? 32'd0 : pcTarget;
  assign bus.PC_Write   = pcWrite | rst;
  assign bus.IFID_Write = ifidWrite | rst;
  assign bus.IFID_Flush = ifidFlush & ~rst;
  assign bus.IDEX_Flush = idexFlush & ~rst;
  assign bus.StallCnt   = stallCnt;
  assign bus.TakenCnt   = takenCnt;

endmodule
